// File: rtl/key_event.sv
// Debounced push-button event generator: press, release, long-press and auto-repeat pulses.
// The raw active-low button is synchronised. The debounce/hold FSM then advances only on
// prescaler ticks, and every output is registered.
module key_event #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned DEB_CNT  = 20,
  parameter int unsigned LONG_CNT = 1000,
  parameter int unsigned REP_CNT  = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sw,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  // Terminal values: a counter that sits at its last value completes the run on this tick.
  localparam logic [15:0] TickLast = 16'(TICK_DIV - 1);
  localparam logic [7:0]  DebLast  = 8'(DEB_CNT - 1);
  localparam logic [15:0] LongLast = 16'(LONG_CNT - 1);
  localparam logic [15:0] RepLast  = 16'(REP_CNT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPressWait,
    StHeld,
    StRepeat,
    StRelWait
  } state_e;

  logic        sw_meta_q, sw_s_q;
  logic [15:0] div_q, div_d;
  logic        tick;
  state_e      state_q, state_d;
  logic [7:0]  deb_q, deb_d;
  logic [15:0] hold_q, hold_d;
  logic        ret_rep_q, ret_rep_d;  // 1 = bounce during release returns to StRepeat
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;
  logic        repeat_q, repeat_d;

  // Two-flop synchroniser; idles at 1 (released) so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= 1'b1;
      sw_s_q    <= 1'b1;
    end else begin
      sw_meta_q <= i_sw;
      sw_s_q    <= sw_meta_q;
    end
  end

  // Sample-tick prescaler: counts 0..TICK_DIV-1, tick on the last count.
  assign tick  = (div_q == TickLast);
  assign div_d = tick ? 16'd0 : div_q + 16'd1;

  // Next-state and registered-output logic; nothing moves except on a tick.
  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    hold_d    = hold_q;
    ret_rep_d = ret_rep_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (!sw_s_q) begin
            deb_d   = 8'd1;
            state_d = StPressWait;
          end
        end
        StPressWait: begin
          if (sw_s_q) begin
            state_d = StIdle;
            deb_d   = 8'd0;
          end else if (deb_q == DebLast) begin
            state_d = StHeld;
            deb_d   = 8'd0;
            hold_d  = 16'd0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            deb_d = deb_q + 8'd1;
          end
        end
        StHeld: begin
          if (sw_s_q) begin
            state_d   = StRelWait;
            deb_d     = 8'd1;
            ret_rep_d = 1'b0;
          end else if (hold_q == LongLast) begin
            state_d = StRepeat;
            hold_d  = 16'd0;
            long_d  = 1'b1;
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end
        StRepeat: begin
          if (sw_s_q) begin
            state_d   = StRelWait;
            deb_d     = 8'd1;
            ret_rep_d = 1'b1;
          end else if (hold_q == RepLast) begin
            hold_d   = 16'd0;
            repeat_d = i_repeat_en;
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end
        StRelWait: begin
          // Release bounce: resume the hold with hold_cnt frozen, no pulse.
          if (!sw_s_q) begin
            state_d = ret_rep_q ? StRepeat : StHeld;
            deb_d   = 8'd0;
          end else if (deb_q == DebLast) begin
            state_d   = StIdle;
            deb_d     = 8'd0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            deb_d = deb_q + 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= 16'd0;
      state_q   <= StIdle;
      deb_q     <= 8'd0;
      hold_q    <= 16'd0;
      ret_rep_q <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      div_q     <= div_d;
      state_q   <= state_d;
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      ret_rep_q <= ret_rep_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with TICK_DIV=4, DEB_CNT=3, LONG_CNT=10, REP_CNT=4.
// Every step drives i_sw for one full tick period and then checks the outputs just after
// the tick edge, where that tick's decisions are visible.
module tb_key_event;

  logic clk = 1'b0;
  logic rst_n;
  logic i_sw;
  logic i_repeat_en;
  logic o_level, o_press, o_release, o_long, o_repeat;

  int n_checks = 0;
  int n_err    = 0;
  int cnt_press = 0, cnt_release = 0, cnt_long = 0, cnt_repeat = 0;

  key_event #(
    .TICK_DIV(4),
    .DEB_CNT (3),
    .LONG_CNT(10),
    .REP_CNT (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sw       (i_sw),
    .i_repeat_en(i_repeat_en),
    .o_level    (o_level),
    .o_press    (o_press),
    .o_release  (o_release),
    .o_long     (o_long),
    .o_repeat   (o_repeat)
  );

  always #5 clk = ~clk;

  // Count high cycles of each pulse; a pulse wider than one clk inflates the totals.
  always @(negedge clk) begin
    if (o_press)   cnt_press++;
    if (o_release) cnt_release++;
    if (o_long)    cnt_long++;
    if (o_repeat)  cnt_repeat++;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " level"},   o_level,   1'b0);
    chk({tag, " press"},   o_press,   1'b0);
    chk({tag, " release"}, o_release, 1'b0);
    chk({tag, " long"},    o_long,    1'b0);
    chk({tag, " repeat"},  o_repeat,  1'b0);
  endtask

  // One tick period with i_sw = sw, then check the outputs produced by that tick.
  task automatic step(input logic sw, input logic e_press, input logic e_long,
                      input logic e_rep, input logic e_rel, input logic e_lvl,
                      input string tag);
    i_sw = sw;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, " press"},   o_press,   e_press);
    chk({tag, " long"},    o_long,    e_long);
    chk({tag, " repeat"},  o_repeat,  e_rep);
    chk({tag, " release"}, o_release, e_rel);
    chk({tag, " level"},   o_level,   e_lvl);
  endtask

  // Hold from IDLE for n ticks: press on tick 3, long on tick 13, repeats every 4 after.
  task automatic hold_run(input int n, input logic en, input string tag);
    logic rep;
    i_repeat_en = en;
    for (int t = 1; t <= n; t++) begin
      rep = en && (t > 13) && (((t - 13) % 4) == 0);
      step(1'b0, t == 3, t == 13, rep, 1'b0, t >= 3, $sformatf("%s t%0d", tag, t));
    end
  endtask

  // Three released ticks: release pulse on the third.
  task automatic rel_run(input string tag);
    for (int t = 1; t <= 3; t++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, t == 3, t < 3, $sformatf("%s t%0d", tag, t));
    end
  endtask

  initial begin
    i_sw        = 1'b1;
    i_repeat_en = 1'b1;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // Clean press followed by a long hold with repeat enabled, then release.
    hold_run(21, 1'b1, "hold_rep");
    rel_run("rel_a");

    // Press bounce: two low ticks then high returns to IDLE, so three more lows are needed.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "pbounce t1");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "pbounce t2");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "pbounce t3");
    for (int t = 1; t <= 3; t++) begin
      step(1'b0, t == 3, 1'b0, 1'b0, 1'b0, t == 3, $sformatf("repress t%0d", t));
    end

    // Release bounce in HELD at hold_cnt=5; the returning tick leaves hold_cnt frozen.
    for (int t = 1; t <= 5; t++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, $sformatf("held t%0d", t));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rbounce t1");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rbounce t2");
    for (int t = 1; t <= 6; t++) begin
      step(1'b0, 1'b0, t == 6, 1'b0, 1'b0, 1'b1, $sformatf("resume t%0d", t));
    end
    rel_run("rel_b");

    // Long hold with repeat disabled, then release.
    hold_run(21, 1'b0, "hold_norep");
    rel_run("rel_c");

    // Reset while in REPEAT with the button still held.
    hold_run(15, 1'b1, "pre_reset");
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    chk_zero("in_reset");
    rst_n = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      step(1'b0, t == 3, 1'b0, 1'b0, 1'b0, t == 3, $sformatf("post_reset t%0d", t));
    end
    @(posedge clk);
    #1;
    chk("post_reset press width", o_press, 1'b0);

    chk_int("total press",   cnt_press,   5);
    chk_int("total release", cnt_release, 3);
    chk_int("total long",    cnt_long,    4);
    chk_int("total repeat",  cnt_repeat,  2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
